stream_fifo: RTL and testbench

- Parameterised valid/ready FIFO inserted between the stimulus generator (upstream, drives valid/data, samples ready) and the checker (downstream, samples valid/data, drives ready).
- Decouples the two sides so differing generator and checker DELAY settings exercise backpressure without losing or duplicating words.
- Reports occupancy and a sticky high-water mark for bench observation.

---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_fifo_mem.sv | 37 +++
 rtl/stream_fifo.sv | 94 +++++++++
 tb/tb_stream_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream definitions used by the generator, the FIFO and the checker.
// Holds the default word width and a parameter-legality helper.
package stream_pkg;

  localparam int STREAM_DW = 16;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
// Contents clear on reset so the read port shows zero while the FIFO is empty after reset.
module stream_fifo_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO between stream generator and checker, no fall-through.
// Tracks occupancy and a sticky high-water mark for observation.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DW    = STREAM_DW,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] max_count_o
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic          init_done_q, init_done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] max_q, max_d;
  logic          push, pop;

  // ready depends only on registered state, so a pop never frees a slot for a same-cycle push
  assign ready_o = init_done_q && (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    init_done_d = 1'b1;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_q       <= '0;
    end else begin
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_q       <= max_d;
    end
  end

  stream_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .raddr (rd_ptr_q),
    .rdata (data_o)
  );

  assign count_o     = count_q;
  assign max_count_o = max_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (DW=16, DEPTH=4): queue-based reference model
// checked every negedge, plus literal expectations for each scenario.
module tb_stream_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_i = 1'b0;
  logic          ready_o, valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] count_o, max_count_o;

  int passed = 0;
  int total  = 0;

  stream_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .max_count_o (max_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a queue of accepted words plus an init flag and high-water mark.
  logic [DW-1:0] mq[$];
  bit            m_init = 1'b0;
  int            m_max  = 0;
  bit            m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_init = 1'b0;
      m_max  = 0;
    end else begin
      m_push = valid_i && m_init && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && ready_i;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(data_i);
      m_init = 1'b1;
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  logic [DW-1:0] out_log[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 32'(ready_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_count", 32'(count_o), 0);
      check("rst_max",   32'(max_count_o), 0);
      check("rst_data",  32'(data_o), 0);
    end else begin
      check("m_ready", 32'(ready_o), 32'(m_init && (mq.size() < DEPTH)));
      check("m_valid", 32'(valid_o), 32'(mq.size() != 0));
      check("m_count", 32'(count_o), 32'(mq.size()));
      check("m_max",   32'(max_count_o), 32'(m_max));
      if (mq.size() != 0) check("m_data", 32'(data_o), 32'(mq[0]));
      if (valid_o && ready_i) out_log.push_back(data_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int i = 0; i < 30 && count_o != 0; i++) step();
    ready_i = 1'b0;
    check("drain_count", 32'(count_o), 0);
  endtask

  task automatic check_seq(input string name, input int first, input int n);
    check({name, "_len"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n && i < out_log.size(); i++)
      check($sformatf("%s_%0d", name, i), 32'(out_log[i]), 32'(first + i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    // 1: reset then idle
    rst = 1'b1;
    repeat (3) step();
    check("t1_ready_in_rst", 32'(ready_o), 0);
    rst = 1'b0;
    #1;
    check("t1_ready_after_release", 32'(ready_o), 0);
    step();
    check("t1_ready_first_edge", 32'(ready_o), 1);
    check("t1_valid", 32'(valid_o), 0);
    check("t1_count", 32'(count_o), 0);

    // 2: single word held under backpressure
    valid_i = 1'b1; data_i = 16'h1234;
    step();
    valid_i = 1'b0;
    check("t2_valid", 32'(valid_o), 1);
    check("t2_data",  32'(data_o), 32'h1234);
    check("t2_count", 32'(count_o), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_data", 32'(data_o), 32'h1234);
      check("t2_hold_valid", 32'(valid_o), 1);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t2_valid_after_pop", 32'(valid_o), 0);
    check("t2_count_after_pop", 32'(count_o), 0);

    // 3: fill and backpressure
    out_log.delete();
    for (int w = 1; w <= 4; w++) begin
      valid_i = 1'b1; data_i = 16'(w);
      check("t3_ready_fill", 32'(ready_o), 1);
      step();
    end
    data_i = 16'h0005;
    step(); step();
    check("t3_ready_full", 32'(ready_o), 0);
    check("t3_count_full", 32'(count_o), 4);
    check("t3_max_full", 32'(max_count_o), 4);
    ready_i = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      accepted = ready_o;
      step();
    end
    check("t3_word5_accepted", 32'(accepted), 1);
    valid_i = 1'b0;
    drain();
    check_seq("t3_seq", 1, 5);
    check("t3_max", 32'(max_count_o), 4);

    // 4: continuous streaming with pointer wrap
    out_log.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1; data_i = 16'(i);
      step();
      check("t4_count", 32'(count_o), 1);
    end
    valid_i = 1'b0;
    step();
    ready_i = 1'b0;
    check("t4_count_end", 32'(count_o), 0);
    check_seq("t4_seq", 0, 20);

    // 5: pop while full does not admit a push in the same cycle
    for (int w = 0; w < 4; w++) begin
      valid_i = 1'b1; data_i = 16'hA0 + 16'(w);
      step();
    end
    data_i = 16'h00A4;
    check("t5_ready_full", 32'(ready_o), 0);
    check("t5_count_full", 32'(count_o), 4);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t5_count_after_pop", 32'(count_o), 3);
    check("t5_ready_after_pop", 32'(ready_o), 1);
    step();
    valid_i = 1'b0;
    check("t5_count_after_push", 32'(count_o), 4);

    // 6: asynchronous reset mid-operation
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t6_count_before", 32'(count_o), 3);
    #2 rst = 1'b1;
    #1;
    check("t6_valid_async", 32'(valid_o), 0);
    check("t6_ready_async", 32'(ready_o), 0);
    check("t6_count_async", 32'(count_o), 0);
    check("t6_max_async", 32'(max_count_o), 0);
    step(); step();
    rst = 1'b0;
    out_log.delete();
    step();
    valid_i = 1'b1; data_i = 16'hBEEF;
    step();
    valid_i = 1'b0;
    check("t6_valid", 32'(valid_o), 1);
    check("t6_data", 32'(data_o), 32'hBEEF);
    check("t6_count", 32'(count_o), 1);
    check("t6_max", 32'(max_count_o), 1);
    drain();
    check("t6_log_len", 32'(out_log.size()), 1);
    if (out_log.size() > 0) check("t6_first_out", 32'(out_log[0]), 32'hBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
